axi_ace_single_master: RTL and testbench

// - Initiator for the single-memory AXI/ACE responder: turns one-at-a-time commands into

---
 rtl/axi_ace_single_master.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_axi_ace_single_master.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ace_single_master.sv
// -----------------------------------------------------------------------------
// axi_ace_single_master
//
// Purpose: single-outstanding initiator for the single-memory AXI/ACE
// responder. Each accepted command becomes one single-beat AXI read, one
// single-beat AXI write or one ACE snoop request. Every accepted command,
// including an illegal one, produces exactly one rsp_valid pulse.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o       command handshake
//   cmd_type_i                      00 read, 01 write, 10 snoop, 11 illegal
//   cmd_addr_i, cmd_wdata_i         word index and write data
//   rsp_valid_o                     one-cycle completion pulse
//   rsp_type_o, rsp_data_o          completed command type, read data (else 0)
//   rsp_err_o                       illegal command or watchdog expiry
//   arvalid_o/arready_i/araddr_o    AXI read address
//   rvalid_i/rready_o/rdata_i       AXI read data
//   awvalid_o/awready_i/awaddr_o    AXI write address
//   wvalid_o/wready_i/wdata_o       AXI write data
//   bvalid_i/bready_o               AXI write response
//   acvalid_o/acready_i/acaddr_o    ACE snoop address
//   crvalid_i/crready_o             ACE snoop response
//
// Build option: define AXI_MASTER_TIMEOUT_EN to add a watchdog that abandons
// a transaction after TIMEOUT_CYCLES cycles and reports rsp_err_o=1.
// Without it the FSM waits indefinitely and TIMEOUT_CYCLES has no effect.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// RD_A    | arvalid high until arready
// RD_D    | rready high until rvalid, read data captured
// WR_AW   | awvalid / wvalid outstanding, each retired independently
// WR_B    | bready high until bvalid
// SNOOP   | acvalid and crready high until acready & crvalid
// DONE    | issue the response pulse, then back to IDLE
// -----------------------------------------------------------------------------
module axi_ace_single_master #(
   parameter int unsigned ADDR_W         = 6,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_type_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   output logic [1:0]        rsp_type_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   output logic [ADDR_W-1:0] araddr_o,
   input  logic              rvalid_i,
   output logic              rready_o,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              awvalid_o,
   input  logic              awready_i,
   output logic [ADDR_W-1:0] awaddr_o,
   output logic              wvalid_o,
   input  logic              wready_i,
   output logic [DATA_W-1:0] wdata_o,
   input  logic              bvalid_i,
   output logic              bready_o,
   output logic              acvalid_o,
   input  logic              acready_i,
   output logic [ADDR_W-1:0] acaddr_o,
   input  logic              crvalid_i,
   output logic              crready_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_A  = 3'd1,
      S_RD_D  = 3'd2,
      S_WR_AW = 3'd3,
      S_WR_B  = 3'd4,
      S_SNOOP = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [1:0]          rsp_type_q, rsp_type_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic                arvalid_q, arvalid_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic                rready_q, rready_d;
   logic                awvalid_q, awvalid_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic                wvalid_q, wvalid_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                bready_q, bready_d;
   logic                acvalid_q, acvalid_d;
   logic [ADDR_W-1:0]   acaddr_q, acaddr_d;
   logic                crready_q, crready_d;
   logic [1:0]          type_q, type_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                err_q, err_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;

   logic                cmd_hs;
   logic                aw_hs;
   logic                w_hs;
   logic                timeout_hit;

   assign cmd_hs = cmd_valid_i & cmd_ready_q;
   assign aw_hs  = awvalid_q & awready_i;
   assign w_hs   = wvalid_q & wready_i;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy;

   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE) begin
         if (cmd_hs) cnt_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   // The watchdog limit is meaningless without the watchdog.
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
   assign timeout_hit           = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = 1'b0;
      rsp_type_d  = '0;
      rsp_data_d  = '0;
      rsp_err_d   = 1'b0;
      arvalid_d   = arvalid_q;
      araddr_d    = araddr_q;
      rready_d    = rready_q;
      awvalid_d   = awvalid_q;
      awaddr_d    = awaddr_q;
      wvalid_d    = wvalid_q;
      wdata_d     = wdata_q;
      bready_d    = bready_q;
      acvalid_d   = acvalid_q;
      acaddr_d    = acaddr_q;
      crready_d   = crready_q;
      type_d      = type_q;
      data_d      = data_q;
      err_d       = err_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_hs) begin
               cmd_ready_d = 1'b0;
               type_d      = cmd_type_i;
               data_d      = '0;
               err_d       = 1'b0;
               case (cmd_type_i)
                  2'b00: begin
                     araddr_d  = cmd_addr_i;
                     arvalid_d = 1'b1;
                     state_d   = S_RD_A;
                  end
                  2'b01: begin
                     awaddr_d  = cmd_addr_i;
                     wdata_d   = cmd_wdata_i;
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     aw_done_d = 1'b0;
                     w_done_d  = 1'b0;
                     state_d   = S_WR_AW;
                  end
                  2'b10: begin
                     // crready goes up with acvalid: the responder only
                     // produces crvalid once it sees acvalid.
                     acaddr_d  = cmd_addr_i;
                     acvalid_d = 1'b1;
                     crready_d = 1'b1;
                     state_d   = S_SNOOP;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end
               endcase
            end
         end

         S_RD_A: begin
            if (arvalid_q && arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_D;
            end
         end

         S_RD_D: begin
            if (rvalid_i && rready_q) begin
               data_d   = rdata_i;
               rready_d = 1'b0;
               state_d  = S_DONE;
            end
         end

         S_WR_AW: begin
            // AW and W retire independently, in either order or together.
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = S_WR_B;
            end
         end

         S_WR_B: begin
            if (bvalid_i && bready_q) begin
               bready_d = 1'b0;
               state_d  = S_DONE;
            end
         end

         S_SNOOP: begin
            if (acready_i && crvalid_i) begin
               acvalid_d = 1'b0;
               crready_d = 1'b0;
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            rsp_valid_d = 1'b1;
            rsp_type_d  = type_q;
            rsp_data_d  = data_q;
            rsp_err_d   = err_q;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Watchdog abandons whatever channel is outstanding.
      if (timeout_hit) begin
         arvalid_d = 1'b0;
         rready_d  = 1'b0;
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         acvalid_d = 1'b0;
         crready_d = 1'b0;
         err_d     = 1'b1;
         data_d    = '0;
         state_d   = S_DONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_type_q  <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         rready_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         awaddr_q    <= '0;
         wvalid_q    <= 1'b0;
         wdata_q     <= '0;
         bready_q    <= 1'b0;
         acvalid_q   <= 1'b0;
         acaddr_q    <= '0;
         crready_q   <= 1'b0;
         type_q      <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_type_q  <= rsp_type_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         arvalid_q   <= arvalid_d;
         araddr_q    <= araddr_d;
         rready_q    <= rready_d;
         awvalid_q   <= awvalid_d;
         awaddr_q    <= awaddr_d;
         wvalid_q    <= wvalid_d;
         wdata_q     <= wdata_d;
         bready_q    <= bready_d;
         acvalid_q   <= acvalid_d;
         acaddr_q    <= acaddr_d;
         crready_q   <= crready_d;
         type_q      <= type_d;
         data_q      <= data_d;
         err_q       <= err_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_type_o  = rsp_type_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign arvalid_o   = arvalid_q;
   assign araddr_o    = araddr_q;
   assign rready_o    = rready_q;
   assign awvalid_o   = awvalid_q;
   assign awaddr_o    = awaddr_q;
   assign wvalid_o    = wvalid_q;
   assign wdata_o     = wdata_q;
   assign bready_o    = bready_q;
   assign acvalid_o   = acvalid_q;
   assign acaddr_o    = acaddr_q;
   assign crready_o   = crready_q;

endmodule

// File: tb/tb_axi_ace_single_master.sv
// -----------------------------------------------------------------------------
// tb_axi_ace_single_master
//
// Drives commands into axi_ace_single_master against a behavioural responder
// with programmable per-channel wait states. Expected responses come from a
// word-array memory model plus the rule that each wait state adds one cycle
// to the zero-wait latency (read 3, write 3, snoop 2, illegal 1).
// -----------------------------------------------------------------------------
module tb_axi_ace_single_master;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 256;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready_o;
   logic [1:0]        cmd_type = '0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_wdata = '0;
   logic              rsp_valid_o;
   logic [1:0]        rsp_type_o;
   logic [DATA_W-1:0] rsp_data_o;
   logic              rsp_err_o;
   logic              arvalid_o, arready, rvalid, rready_o;
   logic [ADDR_W-1:0] araddr_o;
   logic [DATA_W-1:0] rdata;
   logic              awvalid_o, awready, wvalid_o, wready, bvalid, bready_o;
   logic [ADDR_W-1:0] awaddr_o;
   logic [DATA_W-1:0] wdata_o;
   logic              acvalid_o, acready, crvalid, crready_o;
   logic [ADDR_W-1:0] acaddr_o;

   int checks = 0;
   int failures = 0;

   axi_ace_single_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_type_i(cmd_type),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid_o), .rsp_type_o(rsp_type_o), .rsp_data_o(rsp_data_o),
      .rsp_err_o(rsp_err_o),
      .arvalid_o(arvalid_o), .arready_i(arready), .araddr_o(araddr_o),
      .rvalid_i(rvalid), .rready_o(rready_o), .rdata_i(rdata),
      .awvalid_o(awvalid_o), .awready_i(awready), .awaddr_o(awaddr_o),
      .wvalid_o(wvalid_o), .wready_i(wready), .wdata_o(wdata_o),
      .bvalid_i(bvalid), .bready_o(bready_o),
      .acvalid_o(acvalid_o), .acready_i(acready), .acaddr_o(acaddr_o),
      .crvalid_i(crvalid), .crready_o(crready_o)
   );

   always #5 clk = ~clk;

   // ---------------- responder ----------------
   logic [DATA_W-1:0] resp_mem [64];
   logic [DATA_W-1:0] ref_mem  [64];
   int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0, ac_wait = 0;
   int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, ac_cnt;
   bit r_busy, aw_got, w_got, b_busy;
   bit ar_fire, r_fire, aw_fire, w_fire, b_fire, ac_fire;
   bit pv_ar, pv_aw, pv_w, pv_ac;
   logic [ADDR_W-1:0] pa_ar, pa_aw, pa_ac, r_addr, aw_addr_seen, ac_addr_seen;
   logic [DATA_W-1:0] pd_w, w_data_seen;
   int cyc = 0, aw_cyc = 0, w_cyc = 0;
   int activity = 0, wr_seen = 0, rd_seen = 0, sn_seen = 0;
   int proto_err = 0;
   bit proto_en = 1'b1;

   initial begin
      arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0;
      bvalid = 0; acready = 0; crvalid = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ac_cnt = 0;
      r_busy = 0; aw_got = 0; w_got = 0; b_busy = 0;
      ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0; ac_fire = 0;
      pv_ar = 0; pv_aw = 0; pv_w = 0; pv_ac = 0;
      pa_ar = '0; pa_aw = '0; pa_ac = '0; pd_w = '0; r_addr = '0;
      aw_addr_seen = '0; ac_addr_seen = '0; w_data_seen = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            acready = 0; crvalid = 0;
            r_busy = 0; aw_got = 0; w_got = 0; b_busy = 0;
            ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0; ac_fire = 0;
            pv_ar = 0; pv_aw = 0; pv_w = 0; pv_ac = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ac_cnt = 0;
         end else begin
            if (proto_en) begin
               if (pv_ar && !ar_fire && !arvalid_o) proto_err++;
               if (pv_aw && !aw_fire && !awvalid_o) proto_err++;
               if (pv_w && !w_fire && !wvalid_o) proto_err++;
               if (pv_ac && !ac_fire && !acvalid_o) proto_err++;
               if (pv_ar && arvalid_o && araddr_o !== pa_ar) proto_err++;
               if (pv_aw && awvalid_o && awaddr_o !== pa_aw) proto_err++;
               if (pv_w && wvalid_o && wdata_o !== pd_w) proto_err++;
               if (acvalid_o && !crready_o) proto_err++;
            end
            if (arvalid_o | awvalid_o | wvalid_o | acvalid_o | rready_o | bready_o | crready_o)
               activity++;
            // retire handshakes completed on the rising edge just passed
            if (ar_fire) begin r_busy = 1; r_cnt = 0; r_addr = pa_ar; end
            if (r_fire) begin rvalid = 0; r_busy = 0; rd_seen++; end
            if (aw_fire) begin aw_got = 1; aw_addr_seen = pa_aw; aw_cyc = cyc; end
            if (w_fire) begin w_got = 1; w_data_seen = pd_w; w_cyc = cyc; end
            if (aw_got && w_got) begin
               resp_mem[aw_addr_seen] = w_data_seen;
               aw_got = 0; w_got = 0; b_busy = 1; b_cnt = 0;
            end
            if (b_fire) begin bvalid = 0; b_busy = 0; wr_seen++; end
            if (ac_fire) begin ac_addr_seen = pa_ac; sn_seen++; end
            // drive next levels
            arready = 0;
            if (!arvalid_o) ar_cnt = 0;
            else if (!r_busy) begin
               if (ar_cnt >= ar_wait) arready = 1; else ar_cnt++;
            end
            if (r_busy && !rvalid) begin
               if (r_cnt >= r_wait) begin rvalid = 1; rdata = resp_mem[r_addr]; end
               else r_cnt++;
            end
            awready = 0;
            if (!awvalid_o) aw_cnt = 0;
            else if (!aw_got && !b_busy) begin
               if (aw_cnt >= aw_wait) awready = 1; else aw_cnt++;
            end
            wready = 0;
            if (!wvalid_o) w_cnt = 0;
            else if (!w_got && !b_busy) begin
               if (w_cnt >= w_wait) wready = 1; else w_cnt++;
            end
            if (b_busy && !bvalid) begin
               if (b_cnt >= b_wait) bvalid = 1; else b_cnt++;
            end
            acready = 0; crvalid = 0;
            if (!acvalid_o) ac_cnt = 0;
            else if (ac_cnt >= ac_wait) begin acready = 1; crvalid = 1; end
            else ac_cnt++;
            ar_fire = arvalid_o && arready;
            r_fire  = rvalid && rready_o;
            aw_fire = awvalid_o && awready;
            w_fire  = wvalid_o && wready;
            b_fire  = bvalid && bready_o;
            ac_fire = acvalid_o && acready && crvalid && crready_o;
            pv_ar = arvalid_o; pa_ar = araddr_o;
            pv_aw = awvalid_o; pa_aw = awaddr_o;
            pv_w  = wvalid_o;  pd_w  = wdata_o;
            pv_ac = acvalid_o; pa_ac = acaddr_o;
         end
      end
   end

   // ---------------- command driver ----------------
   task automatic do_cmd(input logic [1:0] t, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d,
                         output logic [1:0] ot, output logic [DATA_W-1:0] od,
                         output logic oe, output int lat, output bit ok,
                         output bit rdy_low, output bit pulse_ok);
      int n;
      ok = 0; lat = -1; ot = '0; od = '0; oe = 1'b0; rdy_low = 0; pulse_ok = 0;
      n = 0;
      @(negedge clk);
      while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
      if (!cmd_ready_o) return;
      cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_wdata = d;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_type  = 2'($urandom);
      cmd_addr  = ADDR_W'($urandom);
      cmd_wdata = $urandom;
      rdy_low = !cmd_ready_o;
      n = 0;
      while (!rsp_valid_o && n < 600) begin @(negedge clk); n++; end
      if (!rsp_valid_o) return;
      ok = 1; lat = n; ot = rsp_type_o; od = rsp_data_o; oe = rsp_err_o;
      @(negedge clk);
      pulse_ok = !rsp_valid_o;
   endtask

   function automatic int exp_latency(input logic [1:0] t);
      int m;
      case (t)
         2'b00:   return 3 + ar_wait + r_wait;
         2'b01: begin
            m = (aw_wait > w_wait) ? aw_wait : w_wait;
            return 3 + m + b_wait;
         end
         2'b10:   return 2 + ac_wait;
         default: return 1;
      endcase
   endfunction

   task automatic set_waits(input int ar, input int r, input int aw, input int w,
                            input int b, input int ac);
      ar_wait = ar; r_wait = r; aw_wait = aw; w_wait = w; b_wait = b; ac_wait = ac;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [127:0] all_o;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      all_o = 128'({cmd_ready_o, rsp_valid_o, rsp_type_o, rsp_data_o, rsp_err_o,
                    arvalid_o, araddr_o, rready_o, awvalid_o, awaddr_o, wvalid_o,
                    wdata_o, bready_o, acvalid_o, acaddr_o, crready_o});
      checks++;
      if (all_o !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", all_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_release cmd_ready=%b rsp_valid=%b want 1/0", cmd_ready_o, rsp_valid_o);
      end
   endtask

   task automatic test_write_read();
      logic [1:0] ot; logic [DATA_W-1:0] od; logic oe; int lat; bit ok, rl, po;
      set_waits(0, 0, 0, 0, 0, 0);
      ref_mem[5] = 32'hDEADBEEF;
      do_cmd(2'b01, 6'd5, 32'hDEADBEEF, ot, od, oe, lat, ok, rl, po);
      checks++;
      if (!ok || ot !== 2'b01 || oe !== 1'b0 || od !== '0 || lat != 3) begin
         failures++;
         $display("FAIL write_5 ok=%0d type=%b err=%b data=%h lat=%0d want 1/01/0/0/3", ok, ot, oe, od, lat);
      end
      checks++;
      if (aw_addr_seen !== 6'd5 || w_data_seen !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL write_payload awaddr=%h wdata=%h want 05/deadbeef", aw_addr_seen, w_data_seen);
      end
      checks++;
      if (!rl || !po) begin
         failures++;
         $display("FAIL write_handshake ready_low=%0d pulse_one=%0d want 1/1", rl, po);
      end
      do_cmd(2'b00, 6'd5, 32'h0, ot, od, oe, lat, ok, rl, po);
      checks++;
      if (!ok || ot !== 2'b00 || oe !== 1'b0 || od !== ref_mem[5] || lat != 3) begin
         failures++;
         $display("FAIL read_5 ok=%0d type=%b err=%b data=%h lat=%0d want 1/00/0/%h/3", ok, ot, oe, od, lat, ref_mem[5]);
      end
   endtask

   task automatic test_write_skew();
      logic [1:0] ot; logic [DATA_W-1:0] od; logic oe; int lat, w0, pe0; bit ok, rl, po;
      int awv [3] = '{0, 2, 1};
      int wv  [3] = '{3, 0, 1};
      for (int i = 0; i < 3; i++) begin
         set_waits(0, 0, awv[i], wv[i], 0, 0);
         w0 = wr_seen; pe0 = proto_err;
         ref_mem[10 + i] = 32'hA5A5_0000 + 32'(i);
         do_cmd(2'b01, 6'(10 + i), ref_mem[10 + i], ot, od, oe, lat, ok, rl, po);
         checks++;
         if (!ok || oe !== 1'b0 || lat != exp_latency(2'b01) || wr_seen != w0 + 1 || !po) begin
            failures++;
            $display("FAIL write_skew%0d ok=%0d err=%b lat=%0d want lat=%0d writes=%0d", i, ok, oe, lat, exp_latency(2'b01), wr_seen - w0);
         end
         checks++;
         if (w_cyc - aw_cyc != wv[i] - awv[i] || proto_err != pe0) begin
            failures++;
            $display("FAIL write_order%0d w-aw=%0d want %0d proto=%0d", i, w_cyc - aw_cyc, wv[i] - awv[i], proto_err - pe0);
         end
      end
   endtask

   task automatic test_snoop();
      logic [1:0] ot; logic [DATA_W-1:0] od; logic oe; int lat, pe0; bit ok, rl, po;
      set_waits(0, 0, 0, 0, 0, 0);
      pe0 = proto_err;
      do_cmd(2'b10, 6'h3F, 32'h1234, ot, od, oe, lat, ok, rl, po);
      checks++;
      if (!ok || ot !== 2'b10 || oe !== 1'b0 || od !== '0 || lat != 2) begin
         failures++;
         $display("FAIL snoop_3f ok=%0d type=%b err=%b data=%h lat=%0d want 1/10/0/0/2", ok, ot, oe, od, lat);
      end
      checks++;
      if (ac_addr_seen !== 6'h3F || proto_err != pe0) begin
         failures++;
         $display("FAIL snoop_addr acaddr=%h proto=%0d want 3f/0", ac_addr_seen, proto_err - pe0);
      end
   endtask

   task automatic test_illegal();
      logic [1:0] ot; logic [DATA_W-1:0] od; logic oe; int lat, act0; bit ok, rl, po;
      act0 = activity;
      do_cmd(2'b11, 6'h21, 32'hFFFF_FFFF, ot, od, oe, lat, ok, rl, po);
      checks++;
      if (!ok || ot !== 2'b11 || oe !== 1'b1 || od !== '0 || lat != 1 || !po) begin
         failures++;
         $display("FAIL illegal ok=%0d type=%b err=%b data=%h lat=%0d want 1/11/1/0/1", ok, ot, oe, od, lat);
      end
      checks++;
      if (activity != act0) begin
         failures++;
         $display("FAIL illegal_quiet channel_cycles=%0d want 0", activity - act0);
      end
   endtask

   task automatic test_random();
      logic [1:0] t, ot; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d, od, ed;
      logic oe, ee; int lat, sel, pe0; bit ok, rl, po;
      pe0 = proto_err;
      for (int i = 0; i < 80; i++) begin
         set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         t = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
         a = ADDR_W'($urandom);
         d = $urandom;
         ed = '0; ee = 1'b0;
         case (t)
            2'b00:   ed = ref_mem[a];
            2'b01:   ref_mem[a] = d;
            2'b11:   ee = 1'b1;
            default: ;
         endcase
         do_cmd(t, a, d, ot, od, oe, lat, ok, rl, po);
         checks++;
         if (!ok || ot !== t || od !== ed || oe !== ee) begin
            failures++;
            $display("FAIL rand%0d_rsp type=%b data=%h err=%b want %b/%h/%b ok=%0d", i, ot, od, oe, t, ed, ee, ok);
         end
         checks++;
         if (lat != exp_latency(t) || !rl || !po) begin
            failures++;
            $display("FAIL rand%0d_timing lat=%0d want %0d ready_low=%0d pulse_one=%0d", i, lat, exp_latency(t), rl, po);
         end
      end
      checks++;
      if (proto_err != pe0) begin
         failures++;
         $display("FAIL rand_protocol violations=%0d want 0", proto_err - pe0);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] ot; logic [DATA_W-1:0] od; logic oe; int lat, n, spur; bit ok, rl, po;
      set_waits(1000, 0, 0, 0, 0, 0);
      proto_en = 1'b0;
      n = 0;
      @(negedge clk);
      while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 6'd5;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (arvalid_o !== 1'b1 || araddr_o !== 6'd5) begin
         failures++;
         $display("FAIL midrst_pending arvalid=%b araddr=%h want 1/05", arvalid_o, araddr_o);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, acvalid_o, crready_o,
           rsp_valid_o, cmd_ready_o} !== '0) begin
         failures++;
         $display("FAIL midrst_idle arvalid=%b rready=%b rsp_valid=%b cmd_ready=%b want 0", arvalid_o, rready_o, rsp_valid_o, cmd_ready_o);
      end
      rst_n = 1'b1;
      spur = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid_o || arvalid_o) spur++;
      end
      checks++;
      if (spur != 0) begin
         failures++;
         $display("FAIL midrst_norsp stray_cycles=%0d want 0", spur);
      end
      set_waits(0, 0, 0, 0, 0, 0);
      proto_en = 1'b1;
      do_cmd(2'b00, 6'd5, 32'h0, ot, od, oe, lat, ok, rl, po);
      checks++;
      if (!ok || od !== ref_mem[5] || oe !== 1'b0 || lat != 3) begin
         failures++;
         $display("FAIL midrst_recover ok=%0d data=%h err=%b lat=%0d want %h/0/3", ok, od, oe, lat, ref_mem[5]);
      end
   endtask

`ifdef AXI_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      logic [1:0] ot; logic [DATA_W-1:0] od; logic oe; int lat; bit ok, rl, po;
      set_waits(1000, 0, 0, 0, 0, 0);
      proto_en = 1'b0;
      do_cmd(2'b00, 6'd5, 32'h0, ot, od, oe, lat, ok, rl, po);
      checks++;
      if (!ok || ot !== 2'b00 || oe !== 1'b1 || od !== '0 || lat < TMO || lat > TMO + 4) begin
         failures++;
         $display("FAIL timeout_rd ok=%0d type=%b err=%b data=%h lat=%0d want 1/00/1/0/~%0d", ok, ot, oe, od, lat, TMO);
      end
      checks++;
      if (arvalid_o !== 1'b0 || rready_o !== 1'b0) begin
         failures++;
         $display("FAIL timeout_drop arvalid=%b rready=%b want 0/0", arvalid_o, rready_o);
      end
      set_waits(0, 0, 0, 0, 0, 0);
      proto_en = 1'b1;
   endtask
`else
   task automatic test_long_wait();
      logic [1:0] ot; logic [DATA_W-1:0] od; logic oe; int lat; bit ok, rl, po;
      set_waits(300, 0, 0, 0, 0, 0);
      do_cmd(2'b00, 6'd5, 32'h0, ot, od, oe, lat, ok, rl, po);
      checks++;
      if (!ok || oe !== 1'b0 || od !== ref_mem[5] || lat != 303) begin
         failures++;
         $display("FAIL long_wait ok=%0d err=%b data=%h lat=%0d want 0/%h/303", ok, oe, od, lat, ref_mem[5]);
      end
      set_waits(0, 0, 0, 0, 0, 0);
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) begin
         resp_mem[i] = $urandom;
         ref_mem[i]  = resp_mem[i];
      end
      test_reset();
      test_write_read();
      test_write_skew();
      test_snoop();
      test_illegal();
      test_random();
`ifdef AXI_MASTER_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_watchdog time=%0t limit=500000", $time);
      $fatal(1, "simulation time limit");
   end

endmodule
